// File: rtl/mem_ctrl.sv
// Byte-serial RAM port arbiter between instruction fetch and the load/store buffer.
// Word accesses become per-byte RAM cycles; read bytes are reassembled little-endian.
module mem_ctrl #(
    parameter int IF_BYTES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    rollback,
    input  logic [7:0]              mem_din,
    output logic [7:0]              mem_dout,
    output logic [31:0]             mem_a,
    output logic                    mem_wr,
    input  logic                    io_buffer_full,
    input  logic                    if_en,
    input  logic [31:0]             if_addr,
    output logic                    if_done,
    output logic [8*IF_BYTES-1:0]   if_data,
    input  logic                    lsb_en,
    input  logic                    lsb_wr,
    input  logic [31:0]             lsb_addr,
    input  logic [1:0]              lsb_len,
    input  logic [31:0]             lsb_wdata,
    output logic                    lsb_done,
    output logic [31:0]             lsb_rdata
);

    localparam int CW = $clog2(IF_BYTES + 2) + 1;
    localparam logic GRANT_IF  = 1'b0;
    localparam logic GRANT_LSB = 1'b1;

    typedef enum logic [1:0] {IDLE, IFETCH, LOAD, STORE} state_t;

    state_t                  state_reg, state_next;
    logic [CW-1:0]           cnt_reg, cnt_next;
    logic [CW-1:0]           len_reg, len_next;
    logic                    last_grant_reg, last_grant_next;
    logic [31:0]             mem_a_reg, mem_a_next;
    logic [7:0]              mem_dout_reg, mem_dout_next;
    logic                    mem_wr_reg, mem_wr_next;
    logic [31:0]             wdata_reg, wdata_next;
    logic                    if_done_reg, if_done_next;
    logic [8*IF_BYTES-1:0]   if_data_reg, if_data_next;
    logic                    lsb_done_reg, lsb_done_next;
    logic [31:0]             lsb_rdata_reg, lsb_rdata_next;

    logic                    io_store_blocked;
    logic                    if_cand;
    logic                    lsb_cand;
    logic [CW-1:0]           lsb_len_dec;
    logic [CW-1:0]           step;
    logic [CW-1:0]           byte_idx;

    // A store into IO space must wait while the UART buffer is full.
    assign io_store_blocked = lsb_wr && (lsb_addr[17:16] == 2'b11) && io_buffer_full;
    assign if_cand  = if_en && !rollback;
    assign lsb_cand = lsb_en && (lsb_wr ? !io_store_blocked : !rollback);
    assign step     = cnt_reg + CW'(1);
    assign byte_idx = cnt_reg - CW'(1);

    always_comb begin
        lsb_len_dec = CW'(4);
        case (lsb_len)
            2'b00:   lsb_len_dec = CW'(1);
            2'b01:   lsb_len_dec = CW'(2);
            default: lsb_len_dec = CW'(4);
        endcase
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        len_next        = len_reg;
        last_grant_next = last_grant_reg;
        mem_a_next      = mem_a_reg;
        mem_dout_next   = mem_dout_reg;
        mem_wr_next     = mem_wr_reg;
        wdata_next      = wdata_reg;
        if_data_next    = if_data_reg;
        lsb_rdata_next  = lsb_rdata_reg;
        if_done_next    = 1'b0;
        lsb_done_next   = 1'b0;

        case (state_reg)
            IDLE: begin
                mem_wr_next = 1'b0;
                // Requesters see done one cycle late, so never grant while a done is visible.
                if (!if_done_reg && !lsb_done_reg) begin
                    if (lsb_cand && (!if_cand || last_grant_reg == GRANT_IF)) begin
                        last_grant_next = GRANT_LSB;
                        mem_a_next      = lsb_addr;
                        cnt_next        = '0;
                        len_next        = lsb_len_dec;
                        if (lsb_wr) begin
                            state_next    = STORE;
                            mem_wr_next   = 1'b1;
                            mem_dout_next = lsb_wdata[7:0];
                            wdata_next    = lsb_wdata;
                        end else begin
                            state_next     = LOAD;
                            lsb_rdata_next = '0;
                        end
                    end else if (if_cand) begin
                        last_grant_next = GRANT_IF;
                        state_next      = IFETCH;
                        mem_a_next      = if_addr;
                        cnt_next        = '0;
                        len_next        = CW'(IF_BYTES);
                        if_data_next    = '0;
                    end
                end
            end

            IFETCH, LOAD: begin
                if (rollback) begin
                    state_next  = IDLE;
                    cnt_next    = '0;
                    mem_wr_next = 1'b0;
                end else begin
                    cnt_next = step;
                    if (step < len_reg) begin
                        mem_a_next = mem_a_reg + 32'd1;
                    end
                    // RAM returns data one cycle after the address, so capture lags by two edges.
                    if (cnt_reg != '0) begin
                        if (state_reg == IFETCH) begin
                            if_data_next[8*byte_idx +: 8] = mem_din;
                        end else begin
                            lsb_rdata_next[8*byte_idx[1:0] +: 8] = mem_din;
                        end
                    end
                    if (step == len_reg + CW'(1)) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                        if (state_reg == IFETCH) begin
                            if_done_next = 1'b1;
                        end else begin
                            lsb_done_next = 1'b1;
                        end
                    end
                end
            end

            STORE: begin
                if (step < len_reg) begin
                    cnt_next      = step;
                    mem_a_next    = mem_a_reg + 32'd1;
                    mem_dout_next = wdata_reg[8*step[1:0] +: 8];
                end else begin
                    state_next    = IDLE;
                    cnt_next      = '0;
                    mem_wr_next   = 1'b0;
                    lsb_done_next = 1'b1;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            len_reg        <= '0;
            last_grant_reg <= GRANT_IF;
            mem_a_reg      <= '0;
            mem_dout_reg   <= '0;
            mem_wr_reg     <= 1'b0;
            wdata_reg      <= '0;
            if_done_reg    <= 1'b0;
            if_data_reg    <= '0;
            lsb_done_reg   <= 1'b0;
            lsb_rdata_reg  <= '0;
        end else if (rdy) begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            len_reg        <= len_next;
            last_grant_reg <= last_grant_next;
            mem_a_reg      <= mem_a_next;
            mem_dout_reg   <= mem_dout_next;
            mem_wr_reg     <= mem_wr_next;
            wdata_reg      <= wdata_next;
            if_done_reg    <= if_done_next;
            if_data_reg    <= if_data_next;
            lsb_done_reg   <= lsb_done_next;
            lsb_rdata_reg  <= lsb_rdata_next;
        end
    end

    assign mem_a     = mem_a_reg;
    assign mem_dout  = mem_dout_reg;
    assign mem_wr    = mem_wr_reg;
    assign if_done   = if_done_reg;
    assign if_data   = if_data_reg;
    assign lsb_done  = lsb_done_reg;
    assign lsb_rdata = lsb_rdata_reg;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: requester tasks push expectations, monitors pop on done/write.
// A byte-array RAM model answers reads; a separate model memory yields expected load/fetch data.
module tb_mem_ctrl;
    localparam int IF_BYTES = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        rollback = 1'b0;
    logic [7:0]  mem_din = 8'd0;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full = 1'b0;
    logic        if_en = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic        if_done;
    logic [8*IF_BYTES-1:0] if_data;
    logic        lsb_en = 1'b0;
    logic        lsb_wr = 1'b0;
    logic [31:0] lsb_addr = 32'd0;
    logic [1:0]  lsb_len = 2'd0;
    logic [31:0] lsb_wdata = 32'd0;
    logic        lsb_done;
    logic [31:0] lsb_rdata;

    always #5 clk = ~clk;

    mem_ctrl #(.IF_BYTES(IF_BYTES)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full),
        .if_en(if_en), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .lsb_en(lsb_en), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr), .lsb_len(lsb_len),
        .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata)
    );

    typedef struct {bit chk; logic [31:0] data;} resp_t;
    typedef struct {logic [31:0] a; logic [7:0] d;} wr_t;

    logic [7:0]  ram       [0:65535];
    logic [7:0]  model_mem [0:65535];
    logic [31:0] exp_if[$];
    resp_t       exp_lsb[$];
    wr_t         exp_wr[$];
    int          done_order[$];
    int          checks = 0;
    int          fails = 0;
    logic        prev_if_done = 1'b0;
    logic        prev_lsb_done = 1'b0;
    bit          rand_stop = 1'b0;
    wr_t         wr_item;
    resp_t       resp_item;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic set_mem(input logic [31:0] a, input logic [7:0] d);
        ram[a[15:0]] = d;
        model_mem[a[15:0]] = d;
    endtask

    // RAM model: registered read of the previous cycle's address, gated by rdy.
    always @(posedge clk) begin
        if (rdy) mem_din <= ram[mem_a[15:0]];
    end

    // Write monitor: every RAM write cycle must match the next expected (addr, byte).
    always @(negedge clk) begin
        if (!rst && rdy && mem_wr) begin
            if (exp_wr.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_write: got addr 0x%08h data 0x%02h, expected none", mem_a, mem_dout);
            end else begin
                wr_item = exp_wr.pop_front();
                chk("wr_addr", mem_a, wr_item.a);
                chk("wr_data", 32'(mem_dout), 32'(wr_item.d));
            end
            ram[mem_a[15:0]] <= mem_dout;
        end
    end

    // Done monitor: pops the per-requester scoreboard on each done pulse.
    always @(negedge clk) begin
        if (!rst && rdy) begin
            if (if_done || lsb_done) chk("done_overlap", 32'(if_done && lsb_done), 32'd0);
            if (if_done) begin
                chk("if_done_width", 32'(prev_if_done), 32'd0);
                done_order.push_back(0);
                $display("IF  done data=0x%08h t=%0t", if_data, $time);
                if (exp_if.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_if_done: got if_done=1, expected 0");
                end else begin
                    chk("if_data", if_data, exp_if.pop_front());
                end
            end
            if (lsb_done) begin
                chk("lsb_done_width", 32'(prev_lsb_done), 32'd0);
                done_order.push_back(1);
                $display("LSB done rdata=0x%08h t=%0t", lsb_rdata, $time);
                if (exp_lsb.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_lsb_done: got lsb_done=1, expected 0");
                end else begin
                    resp_item = exp_lsb.pop_front();
                    if (resp_item.chk) chk("lsb_rdata", lsb_rdata, resp_item.data);
                end
            end
            prev_if_done  <= if_done;
            prev_lsb_done <= lsb_done;
        end
    end

    task automatic lsb_req(input bit wr, input logic [31:0] addr, input logic [1:0] len,
                           input logic [31:0] wdata, input bit solo, input bit drop);
        int          L;
        int          n;
        bit          got;
        logic [31:0] a;
        logic [31:0] exp_d;
        L = (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
        exp_d = 32'd0;
        @(posedge clk); #1;
        lsb_en = 1'b1; lsb_wr = wr; lsb_addr = addr; lsb_len = len; lsb_wdata = wdata;
        for (int k = 0; k < L; k++) begin
            a = addr + 32'(k);
            if (wr) begin
                exp_wr.push_back('{a, 8'(wdata >> (8*k))});
                model_mem[a[15:0]] = 8'(wdata >> (8*k));
            end else begin
                exp_d = exp_d | (32'(model_mem[a[15:0]]) << (8*k));
            end
        end
        exp_lsb.push_back('{!wr, exp_d});
        got = 1'b0;
        @(posedge clk);
        for (n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (solo && !wr && n <= L + 2) chk("load_addr", mem_a, addr + 32'(min_i(n - 1, L - 1)));
            if (solo && wr && n <= L) chk("store_wr_high", 32'(mem_wr), 32'd1);
            if (rdy && lsb_done) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            fails++;
            $display("FAIL lsb_timeout: got no lsb_done, expected one within 200 cycles");
        end else if (solo) begin
            chk("lsb_latency", 32'(n - 1), 32'(wr ? L : L + 1));
            if (wr) chk("store_wr_low_at_done", 32'(mem_wr), 32'd0);
        end
        if (drop) begin
            @(posedge clk); #1;
            lsb_en = 1'b0;
        end
    endtask

    task automatic if_req(input logic [31:0] addr, input bit solo, input bit drop);
        int          n;
        bit          got;
        logic [31:0] a;
        logic [31:0] exp_d;
        exp_d = 32'd0;
        @(posedge clk); #1;
        if_en = 1'b1; if_addr = addr;
        for (int k = 0; k < IF_BYTES; k++) begin
            a = addr + 32'(k);
            exp_d = exp_d | (32'(model_mem[a[15:0]]) << (8*k));
        end
        exp_if.push_back(exp_d);
        got = 1'b0;
        @(posedge clk);
        for (n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (solo && n <= IF_BYTES + 2) chk("fetch_addr", mem_a, addr + 32'(min_i(n - 1, IF_BYTES - 1)));
            if (rdy && if_done) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            fails++;
            $display("FAIL if_timeout: got no if_done, expected one within 200 cycles");
        end else if (solo) begin
            chk("if_latency", 32'(n - 1), 32'(IF_BYTES + 1));
        end
        if (drop) begin
            @(posedge clk); #1;
            if_en = 1'b0;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        @(negedge clk);
        chk({tag, "_mem_a"}, mem_a, 32'd0);
        chk({tag, "_mem_dout"}, 32'(mem_dout), 32'd0);
        chk({tag, "_mem_wr"}, 32'(mem_wr), 32'd0);
        chk({tag, "_if_done"}, 32'(if_done), 32'd0);
        chk({tag, "_if_data"}, if_data, 32'd0);
        chk({tag, "_lsb_done"}, 32'(lsb_done), 32'd0);
        chk({tag, "_lsb_rdata"}, lsb_rdata, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, expected finish before 50000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_order[4];
        exp_order = '{1, 0, 1, 0};
        for (int i = 0; i < 65536; i++) begin
            ram[i] = 8'($urandom);
            model_mem[i] = ram[i];
        end
        set_mem(32'h100, 8'h13); set_mem(32'h101, 8'h05);
        set_mem(32'h102, 8'h00); set_mem(32'h103, 8'h00);
        set_mem(32'hFFFF_FFFF, 8'h34); set_mem(32'h0, 8'h12);

        repeat (3) @(posedge clk);
        check_reset_vals("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Both requesters out of reset, re-requesting back to back: round-robin from last=IF.
        done_order.delete();
        fork
            begin
                lsb_req(1'b0, 32'h8000, 2'b10, 32'd0, 1'b0, 1'b0);
                lsb_req(1'b0, 32'h8010, 2'b10, 32'd0, 1'b0, 1'b1);
            end
            begin
                if_req(32'h1000, 1'b0, 1'b0);
                if_req(32'h1010, 1'b0, 1'b1);
            end
        join
        chk("grant_order_len", 32'(done_order.size()), 32'd4);
        for (int i = 0; i < min_i(done_order.size(), 4); i++)
            chk("grant_order", 32'(done_order[i]), 32'(exp_order[i]));

        if_req(32'h100, 1'b1, 1'b1);
        lsb_req(1'b1, 32'h200, 2'b10, 32'hDEAD_BEEF, 1'b1, 1'b1);
        lsb_req(1'b0, 32'h200, 2'b11, 32'd0, 1'b1, 1'b1);
        lsb_req(1'b0, 32'hFFFF_FFFF, 2'b01, 32'd0, 1'b1, 1'b1);

        // Rollback during a load: no done, controller free again afterwards.
        @(posedge clk); #1;
        lsb_en = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h300; lsb_len = 2'b10;
        @(posedge clk);
        @(negedge clk);
        chk("rb_load_first_addr", mem_a, 32'h300);
        @(posedge clk); #1;
        rollback = 1'b1; lsb_en = 1'b0;
        @(posedge clk); #1;
        rollback = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("rb_load_no_done", 32'(lsb_done), 32'd0);
        end
        if_req(32'h400, 1'b1, 1'b1);

        // Rollback during a store at byte 1 is ignored.
        fork
            lsb_req(1'b1, 32'h240, 2'b10, 32'h1234_5678, 1'b1, 1'b1);
            begin
                @(posedge clk); #1;
                @(posedge clk); #1;
                rollback = 1'b1;
                @(posedge clk); #1;
                rollback = 1'b0;
            end
        join

        // IO-space store held off while the UART buffer is full.
        io_buffer_full = 1'b1;
        fork
            lsb_req(1'b1, 32'h0003_0000, 2'b00, 32'h0000_0041, 1'b0, 1'b1);
            begin
                @(posedge clk); #1;
                repeat (3) begin
                    @(posedge clk);
                    @(negedge clk);
                    chk("io_full_no_write", 32'(mem_wr), 32'd0);
                end
                @(posedge clk); #1;
                io_buffer_full = 1'b0;
            end
        join

        // Randomised concurrent traffic with random rdy stalls.
        fork
            begin
                fork
                    repeat (30) if_req(32'h1000 + 32'($urandom_range(0, 255)), 1'b0, 1'($urandom_range(0, 1)));
                    repeat (30) lsb_req(1'($urandom_range(0, 1)), 32'h8000 + 32'($urandom_range(0, 255)),
                                        2'($urandom_range(0, 3)), $urandom, 1'b0, 1'($urandom_range(0, 1)));
                join
                @(posedge clk); #1;
                if_en = 1'b0; lsb_en = 1'b0;
                rand_stop = 1'b1;
            end
            begin
                while (!rand_stop) begin
                    @(posedge clk); #1;
                    rdy = ($urandom_range(0, 3) != 0);
                end
                rdy = 1'b1;
            end
        join
        repeat (3) @(posedge clk);

        // Reset in the middle of a load returns every output to its reset value.
        #1;
        lsb_en = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h500; lsb_len = 2'b10;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1; lsb_en = 1'b0;
        @(posedge clk);
        check_reset_vals("midreset");
        @(posedge clk); #1;
        rst = 1'b0;
        if_req(32'h600, 1'b1, 1'b1);

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("if_queue_empty", 32'(exp_if.size()), 32'd0);
        chk("lsb_queue_empty", 32'(exp_lsb.size()), 32'd0);
        chk("wr_queue_empty", 32'(exp_wr.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
